// File: rtl/gbe_tx_packetizer_if.sv
// ---------------------------------------------------------------------------
// gbe_tx_packetizer_if
// Bundles everything between the packetizer and its surroundings except the
// clock and reset: configuration, the 32-bit input word stream, the byte-wide
// UDP TX bus and the status outputs.
//   slave  : the packetizer side (drives in_ready, app_tx_*, status)
//   master : the application / UDP core side (drives config, stream, afull)
// ---------------------------------------------------------------------------
interface gbe_tx_packetizer_if;
   logic        enable;
   logic [31:0] cfg_destip;
   logic [15:0] cfg_destport;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  app_tx_data;
   logic        app_tx_dvld;
   logic        app_tx_eof;
   logic [31:0] app_tx_destip;
   logic [15:0] app_tx_destport;
   logic        app_tx_afull;
   logic        app_tx_overflow;
   logic [31:0] pkt_count;
   logic        overflow_seen;

   modport master (
      output enable, cfg_destip, cfg_destport, in_data, in_valid,
             app_tx_afull, app_tx_overflow,
      input  in_ready, app_tx_data, app_tx_dvld, app_tx_eof,
             app_tx_destip, app_tx_destport, pkt_count, overflow_seen
   );

   modport slave (
      input  enable, cfg_destip, cfg_destport, in_data, in_valid,
             app_tx_afull, app_tx_overflow,
      output in_ready, app_tx_data, app_tx_dvld, app_tx_eof,
             app_tx_destip, app_tx_destport, pkt_count, overflow_seen
   );
endinterface

// File: rtl/gbe_tx_packetizer.sv
// ---------------------------------------------------------------------------
// gbe_tx_packetizer
// Packs PAYLOAD_WORDS 32-bit words (MSB byte first) into one UDP payload and
// streams it byte by byte to a UDP TX core.
//
// Ports
//   app_clk : single clock, rising edge
//   app_rst : synchronous, active-high reset
//   bus     : gbe_tx_packetizer_if.slave
//             enable / cfg_destip / cfg_destport  - start gating and address
//             in_data / in_valid / in_ready        - input word stream
//             app_tx_data/dvld/eof/destip/destport - byte stream to UDP TX
//             app_tx_afull / app_tx_overflow       - downstream flow status
//             pkt_count / overflow_seen            - status
//
// Build option
//   GBE_TX_PKT_SEQ_HEADER_EN : when defined, every packet is prefixed with
//   the current pkt_count (4 bytes, MSB first). When undefined the header
//   state is never entered and its logic is not built.
// ---------------------------------------------------------------------------
module gbe_tx_packetizer #(
   parameter int PAYLOAD_WORDS = 256
) (
   input  logic                  app_clk,
   input  logic                  app_rst,
   gbe_tx_packetizer_if.slave    bus
);

   localparam int             CW        = $clog2(PAYLOAD_WORDS + 1);
   localparam logic [CW-1:0]  LAST_WORD = CW'(PAYLOAD_WORDS - 1);
   localparam logic [CW-1:0]  ALL_WORDS = CW'(PAYLOAD_WORDS);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t          state_q, state_d;
   logic [31:0]     hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [1:0]      byte_idx_q, byte_idx_d;
   logic [CW-1:0]   acc_cnt_q, acc_cnt_d;     // words accepted this packet
   logic [CW-1:0]   sent_cnt_q, sent_cnt_d;   // words fully transmitted
   logic [31:0]     destip_q, destip_d;
   logic [15:0]     destport_q, destport_d;
   logic [31:0]     pkt_cnt_q, pkt_cnt_d;
   logic            ovf_q, ovf_d;

   logic            start, hdr_act, dvld, xfer_b3, eof, in_ready, in_fire;
   logic [7:0]      tx_data;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   always_comb begin
`ifdef GBE_TX_PKT_SEQ_HEADER_EN
      hdr_act  = (state_q == HDR);
`else
      hdr_act  = 1'b0;
`endif
      start    = (state_q == IDLE) && bus.enable && !bus.app_tx_afull && bus.in_valid;
      // afull gates dvld combinationally so a pause costs zero cycles
      dvld     = (hdr_act || ((state_q == DATA) && hold_full_q)) && !bus.app_tx_afull;
      xfer_b3  = dvld && (state_q == DATA) && (byte_idx_q == 2'd3);
      eof      = xfer_b3 && (sent_cnt_q == LAST_WORD);
      // The holding register may be refilled on the same cycle its last byte
      // leaves, which keeps the byte stream gap-free.
      in_ready = ((state_q != IDLE) || start) && (!hold_full_q || xfer_b3)
                 && (acc_cnt_q != ALL_WORDS);
      in_fire  = in_ready && bus.in_valid;

      tx_data  = 8'h00;
      if (state_q == DATA)
         tx_data = byte_sel(hold_q, byte_idx_q);
`ifdef GBE_TX_PKT_SEQ_HEADER_EN
      if (hdr_act)
         tx_data = byte_sel(pkt_cnt_q, byte_idx_q);
`endif
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      byte_idx_d  = byte_idx_q;
      acc_cnt_d   = acc_cnt_q;
      sent_cnt_d  = sent_cnt_q;
      destip_d    = destip_q;
      destport_d  = destport_q;
      pkt_cnt_d   = pkt_cnt_q;
      ovf_d       = ovf_q | bus.app_tx_overflow;

      if (in_fire) begin
         hold_d      = bus.in_data;
         hold_full_d = 1'b1;
         acc_cnt_d   = acc_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               destip_d   = bus.cfg_destip;
               destport_d = bus.cfg_destport;
               byte_idx_d = 2'd0;
`ifdef GBE_TX_PKT_SEQ_HEADER_EN
               state_d    = HDR;
`else
               state_d    = DATA;
`endif
            end
         end
`ifdef GBE_TX_PKT_SEQ_HEADER_EN
         HDR: begin
            if (dvld) begin
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3)
                  state_d = DATA;
            end
         end
`endif
         DATA: begin
            if (dvld) begin
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  sent_cnt_d = sent_cnt_q + 1'b1;
                  if (!in_fire)
                     hold_full_d = 1'b0;
               end
               if (eof) begin
                  // No restart on the eof cycle: the next packet begins in IDLE.
                  state_d     = IDLE;
                  sent_cnt_d  = '0;
                  acc_cnt_d   = '0;
                  hold_full_d = 1'b0;
                  pkt_cnt_d   = pkt_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         byte_idx_q  <= 2'd0;
         acc_cnt_q   <= '0;
         sent_cnt_q  <= '0;
         destip_q    <= '0;
         destport_q  <= '0;
         pkt_cnt_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         byte_idx_q  <= byte_idx_d;
         acc_cnt_q   <= acc_cnt_d;
         sent_cnt_q  <= sent_cnt_d;
         destip_q    <= destip_d;
         destport_q  <= destport_d;
         pkt_cnt_q   <= pkt_cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.app_tx_data     = tx_data;
   assign bus.app_tx_dvld     = dvld;
   assign bus.app_tx_eof      = eof;
   assign bus.app_tx_destip   = destip_q;
   assign bus.app_tx_destport = destport_q;
   assign bus.pkt_count       = pkt_cnt_q;
   assign bus.overflow_seen   = ovf_q;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
module tb_gbe_tx_packetizer;
   localparam int PW = 2;
`ifdef GBE_TX_PKT_SEQ_HEADER_EN
   localparam int HDR_B = 4;
`else
   localparam int HDR_B = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gbe_tx_packetizer_if bus();
   gbe_tx_packetizer #(.PAYLOAD_WORDS(PW)) dut (.app_clk(clk), .app_rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // stimulus source
   logic [31:0] src_q[$];
   bit          src_on;

   // reference model: expected byte stream {eof,data} and per-packet address
   logic [8:0]  exp_q[$];
   logic [31:0] ip_q[$];
   logic [15:0] port_q[$];
   int          words_acc;
   int          pkt_started;
   logic [31:0] pkt_done;
   bit          ovf_m;

   // values sampled in the last tick
   logic        s_dvld, s_eof, s_ready;
   logic [7:0]  s_data;

   logic [7:0]  got_q[$];
   logic [7:0]  exp_b[$];
   int          lead, gaps;
   bit          got_eof;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete(); ip_q.delete(); port_q.delete();
      words_acc = 0; pkt_started = 0; pkt_done = 32'd0; ovf_m = 1'b0;
   endtask

   task automatic push_word_bytes(input logic [31:0] w, input bit last);
      exp_q.push_back({1'b0, w[31:24]});
      exp_q.push_back({1'b0, w[23:16]});
      exp_q.push_back({1'b0, w[15:8]});
      exp_q.push_back({last, w[7:0]});
   endtask

   // One clock cycle: drive source, sample and score at negedge, step model.
   task automatic tick();
      bus.in_valid = src_on && (src_q.size() > 0);
      bus.in_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      @(negedge clk);
      s_dvld  = bus.app_tx_dvld;
      s_eof   = bus.app_tx_eof;
      s_ready = bus.in_ready;
      s_data  = bus.app_tx_data;

      chk("pkt_count", bus.pkt_count, pkt_done);
      chk("overflow_seen", bus.overflow_seen, {31'd0, ovf_m});

      if (pkt_done == 32'(pkt_started)) begin
         if (!bus.enable || bus.app_tx_afull || !bus.in_valid)
            chk("ready_idle_no_start", {31'd0, bus.in_ready}, 32'd0);
      end else if (words_acc == PW * pkt_started) begin
         chk("ready_after_last_word", {31'd0, bus.in_ready}, 32'd0);
      end

      if (bus.app_tx_dvld) begin
         chk("dvld_while_afull", {31'd0, bus.app_tx_afull}, 32'd0);
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_byte: observed=%h expected=none", bus.app_tx_data);
         end
         if (exp_q.size() > 0) begin
            chk("tx_data", {24'd0, bus.app_tx_data}, {24'd0, exp_q[0][7:0]});
            chk("tx_eof", {31'd0, bus.app_tx_eof}, {31'd0, exp_q[0][8]});
            chk("tx_destip", bus.app_tx_destip, ip_q[0]);
            chk("tx_destport", {16'd0, bus.app_tx_destport}, {16'd0, port_q[0]});
            if (exp_q[0][8]) begin
               void'(ip_q.pop_front());
               void'(port_q.pop_front());
               pkt_done = pkt_done + 32'd1;
            end
            void'(exp_q.pop_front());
         end
      end else begin
         chk("eof_without_dvld", {31'd0, bus.app_tx_eof}, 32'd0);
      end

      if (bus.in_valid && bus.in_ready && !rst) begin
         if (words_acc % PW == 0) begin
`ifdef GBE_TX_PKT_SEQ_HEADER_EN
            push_word_bytes(pkt_done, 1'b0);
`endif
            ip_q.push_back(bus.cfg_destip);
            port_q.push_back(bus.cfg_destport);
            pkt_started++;
         end
         push_word_bytes(src_q[0], (words_acc % PW) == PW - 1);
         words_acc++;
         void'(src_q.pop_front());
      end
      if (bus.app_tx_overflow) ovf_m = 1'b1;

      @(posedge clk);
      if (rst) model_reset();
      #1;
   endtask

   // Tick until an eof transfer; optionally hold afull for 3 cycles once
   // afull_at bytes of this packet have gone out.
   task automatic run_to_eof(input int maxc, input int afull_at);
      int n = 0;
      int afc = 0;
      bit seen = 0;
      got_q.delete(); lead = 0; gaps = 0; got_eof = 0;
      while (!got_eof && n < maxc) begin
         bus.app_tx_afull = (afull_at >= 0) && (got_q.size() == afull_at) && (afc < 3);
         if (bus.app_tx_afull) afc++;
         tick();
         n++;
         if (s_dvld) begin
            seen = 1;
            got_q.push_back(s_data);
            if (s_eof) got_eof = 1;
         end else if (seen) gaps++;
         else lead++;
      end
      bus.app_tx_afull = 1'b0;
      checks++;
      assert (got_eof) else begin
         errors++;
         $error("FAIL eof_timeout: observed=no eof in %0d cycles expected=eof", maxc);
      end
   endtask

   task automatic build_exp(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] ws[3];
      exp_b.delete();
      ws[0] = hdr; ws[1] = w0; ws[2] = w1;
      for (int k = (HDR_B > 0) ? 0 : 1; k < 3; k++)
         for (int j = 3; j >= 0; j--) exp_b.push_back(ws[k][8*j +: 8]);
   endtask

   task automatic cmp_got(input string tag);
      chk({tag, "_len"}, got_q.size(), exp_b.size());
      for (int i = 0; i < got_q.size() && i < exp_b.size(); i++)
         chk({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_b[i]});
   endtask

   task automatic tick_until_bytes(input int nb);
      int cnt = 0;
      int n = 0;
      while (cnt < nb && n < 40) begin
         tick();
         n++;
         if (s_dvld) cnt++;
      end
      chk("bytes_reached", cnt, nb);
   endtask

   initial begin
      logic [31:0] w0, w1, w2, w3;
      rst = 1'b1;
      bus.enable = 1'b0; bus.cfg_destip = 32'h0; bus.cfg_destport = 16'h0;
      bus.in_data = 32'h0; bus.in_valid = 1'b0;
      bus.app_tx_afull = 1'b0; bus.app_tx_overflow = 1'b0;
      src_on = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // reset state
      tick();
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_dvld", {31'd0, bus.app_tx_dvld}, 32'd0);
      chk("rst_eof", {31'd0, bus.app_tx_eof}, 32'd0);
      chk("rst_data", {24'd0, bus.app_tx_data}, 32'd0);
      chk("rst_destip", bus.app_tx_destip, 32'd0);
      chk("rst_pkt_count", bus.pkt_count, 32'd0);
      rst = 1'b0;

      // two words back to back -> 01..08 on consecutive cycles
      bus.enable = 1'b1; bus.cfg_destip = 32'h0A000001; bus.cfg_destport = 16'd5000;
      src_q.push_back(32'h01020304); src_q.push_back(32'h05060708); src_on = 1'b1;
      build_exp(pkt_done, 32'h01020304, 32'h05060708);
      run_to_eof(40, -1);
      cmp_got("basic");
      chk("basic_lead", lead, 1);
      chk("basic_gaps", gaps, 0);
      chk("basic_pkt_count", bus.pkt_count, 32'd1);

      // two packets queued: one idle cycle between them
      w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
      src_q.push_back(w0); src_q.push_back(w1); src_q.push_back(w2); src_q.push_back(w3);
      build_exp(pkt_done, w0, w1);
      run_to_eof(40, -1);
      cmp_got("b2b_a");
      build_exp(pkt_done, w2, w3);
      run_to_eof(40, -1);
      cmp_got("b2b_b");
      chk("b2b_idle_between", lead, 1);
      chk("b2b_gaps", gaps, 0);
      chk("b2b_pkt_count", bus.pkt_count, 32'd3);

      // afull for 3 cycles after the second payload byte
      src_q.push_back(32'hAABBCCDD); src_q.push_back(32'h11223344);
      build_exp(pkt_done, 32'hAABBCCDD, 32'h11223344);
      run_to_eof(40, HDR_B + 2);
      cmp_got("afull");
      chk("afull_gap", gaps, 3);

      // destination change mid-packet is not picked up until the next packet
      bus.cfg_destip = 32'h0A000001;
      src_q.push_back($urandom); src_q.push_back($urandom);
      repeat (3) tick();
      bus.cfg_destip = 32'h0A000002;
      run_to_eof(40, -1);
      chk("destip_held", bus.app_tx_destip, 32'h0A000001);
      src_q.push_back($urandom); src_q.push_back($urandom);
      run_to_eof(40, -1);
      chk("destip_next", bus.app_tx_destip, 32'h0A000002);

      // enable dropped at byte 5: packet completes, nothing else accepted
      src_q.push_back($urandom); src_q.push_back($urandom);
      src_q.push_back($urandom); src_q.push_back($urandom);
      tick_until_bytes(5);
      bus.enable = 1'b0;
      run_to_eof(40, -1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("disabled_ready", {31'd0, s_ready}, 32'd0);
      end
      chk("disabled_src_left", src_q.size(), 2);
      bus.enable = 1'b1;
      run_to_eof(40, -1);
      chk("enable_pkt_count", bus.pkt_count, 32'd8);

      // overflow then reset mid-packet
      src_q.push_back($urandom); src_q.push_back($urandom);
      tick_until_bytes(3);
      bus.app_tx_overflow = 1'b1;
      tick();
      bus.app_tx_overflow = 1'b0;
      tick();
      chk("ovf_sticky", {31'd0, bus.overflow_seen}, 32'd1);
      src_on = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("mid_rst_dvld", {31'd0, bus.app_tx_dvld}, 32'd0);
      chk("mid_rst_eof", {31'd0, bus.app_tx_eof}, 32'd0);
      chk("mid_rst_data", {24'd0, bus.app_tx_data}, 32'd0);
      chk("mid_rst_destip", bus.app_tx_destip, 32'd0);
      chk("mid_rst_destport", {16'd0, bus.app_tx_destport}, 32'd0);
      chk("mid_rst_pkt_count", bus.pkt_count, 32'd0);
      chk("mid_rst_ovf", {31'd0, bus.overflow_seen}, 32'd0);
      src_q.delete();
      src_on = 1'b1;

      // randomized traffic against the scoreboard
      for (int c = 0; c < 800; c++) begin
         if (src_q.size() < 4)
            for (int k = 0; k < PW; k++) src_q.push_back($urandom);
         bus.app_tx_afull = ($urandom_range(0, 3) == 0);
         src_on = ($urandom_range(0, 4) != 0);
         bus.cfg_destip = $urandom;
         bus.cfg_destport = 16'($urandom);
         tick();
      end
      bus.app_tx_afull = 1'b0;
      src_on = 1'b1;
      for (int c = 0; c < 200 && (src_q.size() > 0 || exp_q.size() > 0); c++) tick();
      chk("drain_src", src_q.size(), 0);
      chk("drain_bytes", exp_q.size(), 0);
      chk("final_pkt_count", bus.pkt_count, pkt_done);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gbe_tx_packetizer.md
GBE_TX_PACKETIZER -- requirements
Module: gbe_tx_packetizer

Interface
REQ-001 Parameter PAYLOAD_WORDS, default 256: 32-bit input words per packet, legal range 1..512, so 4..2048 payload bytes.
REQ-002 app_clk  in  1  the only clock; all logic is synchronous to its rising edge.
REQ-003 app_rst  in  1  reset; synchronous and active-high.
REQ-004 enable  in  1  packetizing allowed; sampled only in IDLE.
REQ-005 cfg_destip  in  32  destination IP, latched at packet start.
REQ-006 cfg_destport  in  16  destination UDP port, latched at packet start.
REQ-007 in_data  in  32  input sample word; byte [31:24] is sent first.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  word accepted on any cycle where in_valid=1 and in_ready=1.
REQ-010 app_tx_data  out  8  byte to the UDP TX interface.
REQ-011 app_tx_dvld  out  1  byte valid; one byte is transferred per cycle that is high.
REQ-012 app_tx_eof  out  1  last byte of packet; qualified by app_tx_dvld.
REQ-013 app_tx_destip  out  32  latched cfg_destip.
REQ-014 app_tx_destport  out  16  latched cfg_destport.
REQ-015 app_tx_afull  in  1  downstream TX FIFO almost full.
REQ-016 app_tx_overflow  in  1  downstream overflow flag.
REQ-017 pkt_count  out  32  packets completed; wraps from 0xFFFFFFFF to 0.
REQ-018 overflow_seen  out  1  sticky; set by app_tx_overflow, cleared only by reset.

Function
REQ-019 States: IDLE, HDR, DATA.
- IDLE -> HDR when enable=1, app_tx_afull=0 and in_valid=1.
- HDR -> DATA after the 4th header byte.
- DATA -> IDLE on the byte that carries app_tx_eof.
REQ-020 On the IDLE exit cycle, cfg_destip and cfg_destport are latched into app_tx_destip and app_tx_destport; both outputs hold constant for the whole packet.
REQ-021 A one-word holding register with a 2-bit byte index feeds app_tx_data.
- in_ready = (state != IDLE or IDLE exit condition true) and (holding empty or a byte-3 transfer occurs this cycle).
- in_ready is forced 0 once PAYLOAD_WORDS words of the current packet have been accepted.
REQ-022 app_tx_dvld = (state is HDR) or (state is DATA and holding register full), and app_tx_afull=0.
- app_tx_dvld is combinational in app_tx_afull, with zero-cycle pause.
- Byte index and word counters advance only on transferred bytes.
REQ-023 app_tx_eof = 1 exactly on byte 3 of word PAYLOAD_WORDS-1 of a packet.
REQ-024 A sustained stream (in_valid=1, afull=0) yields one byte per cycle with no gaps inside a packet; there is at most 1 idle cycle between packets.
REQ-025 enable deasserted mid-packet has no effect; the packet completes, then the block stays in IDLE.
REQ-026 app_tx_afull rising mid-word stalls on the current byte index; the same byte is re-presented when afull falls.
REQ-027 in_valid low mid-packet stalls dvld at the word boundary; no padding or early eof is generated.
REQ-028 pkt_count increments on the cycle of the eof transfer.
REQ-029 A simultaneous eof transfer and a valid next-packet start condition is resolved as IDLE on the next cycle; the new packet starts one cycle later.

Reset
REQ-030 With app_rst=1 at a clock edge, on the next cycle:
- state=IDLE, holding register empty, counters 0;
- in_ready=0, app_tx_dvld=0, app_tx_eof=0;
- app_tx_data=0, app_tx_destip=0, app_tx_destport=0;
- pkt_count=0, overflow_seen=0.
REQ-031 Reset mid-packet abandons the packet without eof; the partially written downstream frame is cleared by the separate app_tx_rst.

Configuration
REQ-032 Macro GBE_TX_PKT_SEQ_HEADER_EN, when defined:
- HDR is used and emits the current pkt_count as 4 bytes, MSB first, before the payload;
- packet length = 4 + 4*PAYLOAD_WORDS bytes.
REQ-033 Macro GBE_TX_PKT_SEQ_HEADER_EN, when undefined:
- HDR is skipped and IDLE goes directly to DATA;
- packet length = 4*PAYLOAD_WORDS bytes;
- header logic is not synthesized.

Verification
REQ-034 PAYLOAD_WORDS=2, macro off, words 0x01020304 and 0x05060708 back-to-back -> bytes 01..08 on 8 consecutive dvld cycles, eof with 08, pkt_count=1.
REQ-035 Macro on, PAYLOAD_WORDS=1, three packets -> headers 00000000, 00000001, 00000002 each precede 4 payload bytes, pkt_count=3.
REQ-036 afull pulsed high for 3 cycles after the 2nd byte of 0xAABBCCDD -> sequence AA BB (gap of 3) CC DD; no byte duplicated or lost.
REQ-037 cfg_destip changed from 10.0.0.1 to 10.0.0.2 mid-packet -> app_tx_destip stays 0x0A000001 until the next packet starts.
REQ-038 enable dropped at byte 5 of an 8-byte packet -> packet completes with eof; next in_valid is not accepted.
REQ-039 app_rst asserted at byte 3 of a packet -> next cycle all outputs are 0 and state is IDLE; app_tx_overflow pulse before reset leaves overflow_seen=0 after reset.
